// File: rtl/branch_redirect_ctrl_if.sv
// ----------------------------------------------------------------------------
// branch_redirect_ctrl_if
//
// Purpose:
//   Bundles the two handshakes around the branch redirect controller:
//     - the EX-stage side, which presents a resolved branch/jump result and
//       is stalled through ex_ready_o;
//     - the fetch side, which receives the PC redirect as a valid/ready pair.
//
// Signals:
//   ex_valid_i      EX holds a valid branch/jump-unit result this cycle
//   ex_jump_en_i    branch/jump taken
//   ex_jump_addr_i  taken target (64 bit)
//   ex_ready_o      EX may retire its op; low stalls EX
//   redir_valid_o   PC redirect request to fetch
//   redir_addr_o    redirect target (64 bit)
//   redir_ready_i   fetch accepts the redirect this cycle
//
// Modports:
//   master  the pipeline/fetch environment: drives the *_i signals
//   slave   the redirect controller: drives the *_o signals
// ----------------------------------------------------------------------------
interface branch_redirect_ctrl_if;

    logic        ex_valid_i;
    logic        ex_jump_en_i;
    logic [63:0] ex_jump_addr_i;
    logic        ex_ready_o;

    logic        redir_valid_o;
    logic [63:0] redir_addr_o;
    logic        redir_ready_i;

    modport master (
        output ex_valid_i,
        output ex_jump_en_i,
        output ex_jump_addr_i,
        input  ex_ready_o,
        input  redir_valid_o,
        input  redir_addr_o,
        output redir_ready_i
    );

    modport slave (
        input  ex_valid_i,
        input  ex_jump_en_i,
        input  ex_jump_addr_i,
        output ex_ready_o,
        output redir_valid_o,
        output redir_addr_o,
        input  redir_ready_i
    );

endinterface

// File: rtl/branch_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Purpose:
//   Turns a taken branch/jump resolved in EX into a PC redirect towards fetch.
//   On a taken, 4-byte aligned target the younger IF/ID and ID/EX contents are
//   killed in the same cycle, the target is latched, and a redirect request is
//   held towards fetch until accepted. While the redirect is outstanding EX is
//   stalled and the wrong-path kill is kept asserted. A taken but misaligned
//   target raises a one-cycle misalign pulse instead and records the address.
//   Completed redirects are counted with a saturating counter.
//
// Parameters:
//   CNT_W            width of the redirect statistics counter
//
// Ports:
//   clk              single clock, rising-edge
//   rst_n            asynchronous, active-low reset
//   bus              slave side of branch_redirect_ctrl_if (EX + fetch handshakes)
//   flush_if_id_o    kill the IF/ID register contents
//   flush_id_ex_o    kill the ID/EX register contents
//   misalign_o       one-cycle pulse: taken target not 4-byte aligned
//   misalign_addr_o  last offending target, held until the next misalignment
//   redir_cnt_o      number of completed redirects (saturating)
//
// States:
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no redirect outstanding; EX may retire, captures allowed
//   REQ   | redirect presented to fetch; EX stalled, wrong path flushed
// ----------------------------------------------------------------------------
module branch_redirect_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    branch_redirect_ctrl_if.slave    bus,
    output logic                     flush_if_id_o,
    output logic                     flush_id_ex_o,
    output logic                     misalign_o,
    output logic [63:0]              misalign_addr_o,
    output logic [CNT_W-1:0]         redir_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [63:0]        target_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               misalign_q;
    logic [63:0]        misalign_addr_q;

    logic               taken;
    logic               aligned;
    logic               capture;
    logic               misalign_evt;
    logic               handshake;

    logic               ex_ready;
    logic               redir_valid;
    logic [63:0]        redir_addr;
    logic               flush;

    // ------------------------------------------------------------------------
    // Event decode. Only IDLE looks at EX; in REQ the stall (ex_ready_o=0)
    // keeps EX frozen, so its inputs carry no new information.
    // ------------------------------------------------------------------------
    assign taken        = bus.ex_valid_i && bus.ex_jump_en_i;
    assign aligned      = (bus.ex_jump_addr_i[1:0] == 2'b00);
    assign capture      = (state_q == IDLE) && taken && aligned;
    assign misalign_evt = (state_q == IDLE) && taken && !aligned;

    // redir_ready_i only matters while a request is actually presented.
    assign handshake    = (state_q == REQ) && bus.redir_ready_i;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ex_ready    = 1'b1;
        redir_valid = 1'b0;
        redir_addr  = 64'd0;
        flush       = 1'b0;

        case (state_q)
            IDLE: begin
                // Kill the wrong path in the capture cycle itself so the
                // younger ops never advance behind the taken branch.
                if (capture) begin
                    flush   = 1'b1;
                    state_d = REQ;
                end
            end

            REQ: begin
                ex_ready    = 1'b0;
                redir_valid = 1'b1;
                redir_addr  = target_q;
                // Fetch keeps delivering wrong-path words until it turns,
                // so the kill is held for the whole request.
                flush       = 1'b1;
                if (bus.redir_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Redirect target. Only written on capture, so the address presented to
    // fetch is stable for the whole REQ period regardless of EX activity.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= 64'd0;
        end else if (capture) begin
            target_q <= bus.ex_jump_addr_i;
        end
    end

    // ------------------------------------------------------------------------
    // Saturating redirect counter. A reset during REQ drops the request
    // before any handshake, so an abandoned redirect is never counted.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (handshake && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Misalignment report: registered pulse one cycle after the event, with
    // the offending address latched on the same edge and held afterwards.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= 64'd0;
        end else begin
            misalign_q <= misalign_evt;
            if (misalign_evt) begin
                misalign_addr_q <= bus.ex_jump_addr_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign bus.ex_ready_o    = ex_ready;
    assign bus.redir_valid_o = redir_valid;
    assign bus.redir_addr_o  = redir_addr;

    assign flush_if_id_o     = flush;
    assign flush_id_ex_o     = flush;
    assign misalign_o        = misalign_q;
    assign misalign_addr_o   = misalign_addr_q;
    assign redir_cnt_o       = cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// tb_branch_redirect_ctrl
//
// Directed stimulus with a scoreboard: every redirect or misalignment the
// stimulus provokes pushes its expected response into a queue; monitor
// processes pop and compare whenever a DUT completes a redirect handshake or
// raises misalign_o. A second instance with CNT_W=4 covers counter saturation.
// ----------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] cnt_before;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    branch_redirect_ctrl_if bus ();
    branch_redirect_ctrl_if bus4 ();

    logic        flush_if_id, flush_id_ex, misalign;
    logic [63:0] misalign_addr;
    logic [31:0] redir_cnt;

    logic        flush_if_id4, flush_id_ex4, misalign4;
    logic [63:0] misalign_addr4;
    logic [3:0]  redir_cnt4;

    branch_redirect_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .flush_if_id_o   (flush_if_id),
        .flush_id_ex_o   (flush_id_ex),
        .misalign_o      (misalign),
        .misalign_addr_o (misalign_addr),
        .redir_cnt_o     (redir_cnt)
    );

    branch_redirect_ctrl #(.CNT_W(4)) dut4 (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus4),
        .flush_if_id_o   (flush_if_id4),
        .flush_id_ex_o   (flush_id_ex4),
        .misalign_o      (misalign4),
        .misalign_addr_o (misalign_addr4),
        .redir_cnt_o     (redir_cnt4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    exp_t exp_q[$];
    exp_t exp4_q[$];
    logic [63:0] mis_q[$];

    exp_t        e_mon;
    exp_t        e4_mon;
    logic [63:0] m_mon;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (bus.redir_valid_o && bus.redir_ready_i) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL redir_unexpected: got addr 0x%0h, expected no redirect (t=%0t)",
                         bus.redir_addr_o, $time);
            end else begin
                e_mon = exp_q.pop_front();
                check("redir_addr", bus.redir_addr_o, e_mon.addr);
                check("redir_cnt_before", 64'(redir_cnt), e_mon.cnt_before);
            end
        end
        if (misalign) begin
            if (mis_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL misalign_unexpected: got addr 0x%0h, expected no pulse (t=%0t)",
                         misalign_addr, $time);
            end else begin
                m_mon = mis_q.pop_front();
                check("misalign_addr", misalign_addr, m_mon);
            end
        end
        if (bus4.redir_valid_o && bus4.redir_ready_i) begin
            if (exp4_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL redir4_unexpected: got addr 0x%0h, expected no redirect (t=%0t)",
                         bus4.redir_addr_o, $time);
            end else begin
                e4_mon = exp4_q.pop_front();
                check("redir4_addr", bus4.redir_addr_o, e4_mon.addr);
                check("redir4_cnt_before", 64'(redir_cnt4), e4_mon.cnt_before);
            end
        end
    end

    // --------------------------------------------------------------- watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by t=%0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        rst_n               = 1'b0;
        bus.ex_valid_i      = 1'b0;
        bus.ex_jump_en_i    = 1'b0;
        bus.ex_jump_addr_i  = 64'd0;
        bus.redir_ready_i   = 1'b0;
        bus4.ex_valid_i     = 1'b0;
        bus4.ex_jump_en_i   = 1'b0;
        bus4.ex_jump_addr_i = 64'd0;
        bus4.redir_ready_i  = 1'b1;

        // Reset state
        #3;
        check("rst_ex_ready", 64'(bus.ex_ready_o), 64'd1);
        check("rst_redir_valid", 64'(bus.redir_valid_o), 64'd0);
        check("rst_redir_addr", bus.redir_addr_o, 64'd0);
        check("rst_flush", 64'({flush_if_id, flush_id_ex}), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        check("rst_cnt", 64'(redir_cnt), 64'd0);

        // Aligned jump, fetch ready at once; capture on the first edge after release
        @(negedge clk);
        @(negedge clk);
        rst_n              = 1'b1;
        bus.ex_valid_i     = 1'b1;
        bus.ex_jump_en_i   = 1'b1;
        bus.ex_jump_addr_i = 64'h8000_0100;
        bus.redir_ready_i  = 1'b1;
        exp_q.push_back('{64'h8000_0100, 64'd0});
        #1;
        check("t1_cap_flush_if_id", 64'(flush_if_id), 64'd1);
        check("t1_cap_flush_id_ex", 64'(flush_id_ex), 64'd1);
        check("t1_cap_ex_ready", 64'(bus.ex_ready_o), 64'd1);
        check("t1_cap_redir_valid", 64'(bus.redir_valid_o), 64'd0);
        @(posedge clk); #1;
        bus.ex_valid_i = 1'b0;
        @(negedge clk);
        check("t1_req_valid", 64'(bus.redir_valid_o), 64'd1);
        check("t1_req_ex_ready", 64'(bus.ex_ready_o), 64'd0);
        check("t1_req_flush", 64'({flush_if_id, flush_id_ex}), 64'd3);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_idle_valid", 64'(bus.redir_valid_o), 64'd0);
        check("t1_idle_addr", bus.redir_addr_o, 64'd0);
        check("t1_cnt", 64'(redir_cnt), 64'd1);

        // Fetch back-pressure for 3 cycles, EX holds its inputs while stalled
        @(posedge clk); #1;
        bus.ex_valid_i     = 1'b1;
        bus.ex_jump_en_i   = 1'b1;
        bus.ex_jump_addr_i = 64'h8000_0200;
        bus.redir_ready_i  = 1'b0;
        exp_q.push_back('{64'h8000_0200, 64'd1});
        @(negedge clk);
        check("t2_cap_flush", 64'({flush_if_id, flush_id_ex}), 64'd3);
        check("t2_cap_redir_valid", 64'(bus.redir_valid_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin
                bus.redir_ready_i = 1'b1;
                bus.ex_valid_i    = 1'b0;
            end
            @(negedge clk);
            check("t2_req_valid", 64'(bus.redir_valid_o), 64'd1);
            check("t2_req_addr", bus.redir_addr_o, 64'h8000_0200);
            check("t2_req_ex_ready", 64'(bus.ex_ready_o), 64'd0);
            check("t2_req_flush", 64'({flush_if_id, flush_id_ex}), 64'd3);
            check("t2_req_cnt", 64'(redir_cnt), 64'd1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_idle_valid", 64'(bus.redir_valid_o), 64'd0);
        check("t2_cnt", 64'(redir_cnt), 64'd2);

        // Misaligned target
        @(posedge clk); #1;
        bus.ex_valid_i     = 1'b1;
        bus.ex_jump_en_i   = 1'b1;
        bus.ex_jump_addr_i = 64'h8000_0102;
        mis_q.push_back(64'h8000_0102);
        @(negedge clk);
        check("t3_evt_flush", 64'({flush_if_id, flush_id_ex}), 64'd0);
        check("t3_evt_ex_ready", 64'(bus.ex_ready_o), 64'd1);
        check("t3_evt_misalign", 64'(misalign), 64'd0);
        @(posedge clk); #1;
        bus.ex_valid_i = 1'b0;
        @(negedge clk);
        check("t3_pulse", 64'(misalign), 64'd1);
        check("t3_redir_valid", 64'(bus.redir_valid_o), 64'd0);
        check("t3_flush", 64'({flush_if_id, flush_id_ex}), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_pulse_end", 64'(misalign), 64'd0);
        check("t3_addr_hold", misalign_addr, 64'h8000_0102);
        check("t3_cnt", 64'(redir_cnt), 64'd2);

        // Not-taken results for 10 cycles; redir_ready_i in IDLE is ignored
        bus.redir_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.ex_valid_i     = 1'b1;
            bus.ex_jump_en_i   = 1'b0;
            bus.ex_jump_addr_i = 64'h8000_0400 + 64'(i) * 64'd4;
            @(negedge clk);
            check("t4_flush", 64'({flush_if_id, flush_id_ex}), 64'd0);
            check("t4_redir_valid", 64'(bus.redir_valid_o), 64'd0);
        end
        @(posedge clk); #1;
        bus.ex_valid_i = 1'b0;
        @(negedge clk);
        check("t4_cnt", 64'(redir_cnt), 64'd2);

        // Reset while a redirect is pending
        @(posedge clk); #1;
        bus.ex_valid_i     = 1'b1;
        bus.ex_jump_en_i   = 1'b1;
        bus.ex_jump_addr_i = 64'h8000_0300;
        bus.redir_ready_i  = 1'b0;
        exp_q.push_back('{64'h8000_0300, 64'd2});
        @(posedge clk); #1;
        bus.ex_valid_i = 1'b0;
        @(negedge clk);
        check("t5_req_valid", 64'(bus.redir_valid_o), 64'd1);
        #2;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("t5_rst_valid", 64'(bus.redir_valid_o), 64'd0);
        check("t5_rst_addr", bus.redir_addr_o, 64'd0);
        check("t5_rst_flush", 64'({flush_if_id, flush_id_ex}), 64'd0);
        check("t5_rst_ex_ready", 64'(bus.ex_ready_o), 64'd1);
        check("t5_rst_cnt", 64'(redir_cnt), 64'd0);
        check("t5_rst_misalign_addr", misalign_addr, 64'd0);
        bus.redir_ready_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_post_valid", 64'(bus.redir_valid_o), 64'd0);
        check("t5_post_cnt", 64'(redir_cnt), 64'd0);

        // CNT_W=4: 17 back-to-back redirects, counter saturates at 15
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            bus4.ex_valid_i     = 1'b1;
            bus4.ex_jump_en_i   = 1'b1;
            bus4.ex_jump_addr_i = 64'h1000 + 64'(i) * 64'd16;
            exp4_q.push_back('{64'h1000 + 64'(i) * 64'd16, (i > 15) ? 64'd15 : 64'(i)});
            @(posedge clk); #1;
            bus4.ex_valid_i = 1'b0;
        end
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_cnt_sat", 64'(redir_cnt4), 64'd15);
        check("t6_valid", 64'(bus4.redir_valid_o), 64'd0);

        // Every scoreboard entry consumed
        check("sb_redir_left", 64'(exp_q.size()), 64'd0);
        check("sb_redir4_left", 64'(exp4_q.size()), 64'd0);
        check("sb_misalign_left", 64'(mis_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the width of the redirect statistics counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ex_valid_i  input  1  EX stage holds a valid branch/jump-unit result this cycle.
REQ-005 SHALL have port ex_jump_en_i  input  1  branch/jump taken (from bju npc_jump_en_o).
REQ-006 SHALL have port ex_jump_addr_i  input  64  taken target (from bju npc_jump_addr_o).
REQ-007 SHALL have port ex_ready_o  output  1  EX may retire its op; low stalls EX, which then holds its inputs stable.
REQ-008 SHALL have port redir_valid_o  output  1  PC redirect request to fetch.
REQ-009 SHALL have port redir_addr_o  output  64  redirect target.
REQ-010 SHALL have port redir_ready_i  input  1  fetch accepts the redirect this cycle.
REQ-011 SHALL have port flush_if_id_o  output  1  kill the IF/ID register contents.
REQ-012 SHALL have port flush_id_ex_o  output  1  kill the ID/EX register contents.
REQ-013 SHALL have port misalign_o  output  1  one-cycle pulse: taken target not 4-byte aligned.
REQ-014 SHALL have port misalign_addr_o  output  64  offending target; holds value until the next misalignment.
REQ-015 SHALL have port redir_cnt_o  output  CNT_W  number of completed redirects.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and REQ.
REQ-017 Capture event SHALL be: state IDLE, ex_valid_i=1, ex_jump_en_i=1, ex_jump_addr_i[1:0]=0.
REQ-018 On a capture event, flush_if_id_o and flush_id_ex_o SHALL be 1 combinationally in that same cycle.
REQ-019 On a capture event, ex_jump_addr_i SHALL be registered into the target register, and the FSM SHALL go to REQ on the next edge.
REQ-020 In IDLE, ex_ready_o SHALL be 1, redir_valid_o SHALL be 0, and redir_addr_o SHALL be 0.
REQ-021 In REQ: redir_valid_o=1, redir_addr_o=target register, ex_ready_o=0, flush_if_id_o=1, flush_id_ex_o=1 (wrong-path kill continues until fetch turns).
REQ-022 In REQ, redir_valid_o and redir_addr_o SHALL stay stable until redir_ready_i=1.
REQ-023 A redirect handshake SHALL complete on a cycle with redir_valid_o=1 and redir_ready_i=1; FSM then returns to IDLE on the next edge.
REQ-024 Redirect latency SHALL be one cycle: redir_valid_o rises on the edge after the capture event; minimum occupancy is one REQ cycle.
REQ-025 redir_cnt_o SHALL increment by 1 on each handshake and saturate at all-ones (no wrap).
REQ-026 ex_valid_i=1 with ex_jump_en_i=0 SHALL produce no flush, no redirect, and no state change.
REQ-027 ex_valid_i=0 SHALL cause every input other than redir_ready_i to be ignored.
REQ-028 Misalign event (IDLE, ex_valid_i=1, ex_jump_en_i=1, ex_jump_addr_i[1:0]!=0): no redirect, no flush, FSM stays in IDLE.
REQ-029 On a misalign event, misalign_o SHALL pulse high exactly in the following cycle, and misalign_addr_o SHALL take the offending address on the same edge.
REQ-030 In REQ, EX inputs SHALL be ignored; ex_ready_o=0 guarantees no new capture.
REQ-031 After a handshake, a capture SHALL be possible in the first IDLE cycle, giving back-to-back redirects every 2 cycles minimum.
REQ-032 redir_ready_i while in IDLE SHALL be ignored.

Reset
REQ-033 rst_n=0 SHALL immediately force: FSM=IDLE, target register=0, redir_cnt_o=0, misalign_o=0, misalign_addr_o=0, redir_valid_o=0, flush outputs 0, ex_ready_o=1.
REQ-034 rst_n=0 during REQ SHALL abandon the pending redirect; no handshake is counted.
REQ-035 The first capture SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-036 Taken jump to 0x8000_0100, redir_ready_i=1 -> flush in capture cycle; next cycle redir_valid_o=1 with addr 0x8000_0100; then IDLE; redir_cnt_o=1.
REQ-037 Taken jump to 0x8000_0200, redir_ready_i low 3 cycles -> ex_ready_o=0 and both flushes=1 for 4 REQ cycles, addr stable; count +1 only on the accept cycle.
REQ-038 Taken jump to 0x8000_0102 -> misalign_o pulses 1 cycle later, misalign_addr_o=0x8000_0102, no flush/redirect, count unchanged.
REQ-039 rst_n asserted mid-REQ -> outputs reset immediately; redir_cnt_o unchanged (0) after reset release.
REQ-040 CNT_W=4, 17 redirects -> redir_cnt_o saturates at 15.
REQ-041 ex_valid_i=1, ex_jump_en_i=0 for 10 cycles -> no flush, redir_valid_o=0 throughout.
